// File: rtl/alu_mul_sequencer.sv
// Shift-add MUL sequencer that borrows the shared EX-stage ALU.
// Optional MUL_EARLY_EXIT_EN ends iteration once no multiplier bits remain.
module alu_mul_sequencer #(
    parameter int          WIDTH      = 64,
    parameter logic [10:0] MUL_OPCODE = 11'b10011011000,
    parameter logic [3:0]  ALU_ADD    = 4'b0010
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [10:0]      opcode,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    input  logic [WIDTH-1:0] ex_a,
    input  logic [WIDTH-1:0] ex_b,
    input  logic [3:0]       ex_alucnt,
    input  logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_cnt,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             last;

    assign accept = (state == IDLE) & start & (opcode == MUL_OPCODE) & ~flush;

`ifdef MUL_EARLY_EXIT_EN
    // Stop once the bits still to be consumed are all zero.
    assign last = (cnt == CNT_LAST) | ((mplier >> 1) == '0);
`else
    assign last = (cnt == CNT_LAST);
`endif

    always_comb begin
        state_n = state;
        alu_a   = ex_a;
        alu_b   = ex_b;
        alu_cnt = ex_alucnt;
        stall   = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE: begin
                stall = accept;
                if (accept) begin
                    state_n = RUN;
                end
            end
            RUN: begin
                alu_a   = acc;
                alu_b   = mplier[0] ? mcand : '0;
                alu_cnt = ALU_ADD;
                stall   = 1'b1;
                if (flush) begin
                    state_n = IDLE;
                end else if (last) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                done    = ~flush;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                acc    <= '0;
                mcand  <= op_a;
                mplier <= op_b;
                cnt    <= '0;
            end else if ((state == RUN) && !flush) begin
                // A flushed iteration leaves acc as it was.
                acc    <= alu_result;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + CW'(1);
            end
        end
    end

    assign product = acc;

endmodule
